// File: rtl/kernel_mac_conv_if.sv
// Handshake/data bundle for the sequential KxK convolution engine.
// master drives the request side (start, window, kernel).
// slave is the engine itself and returns busy/done/result/sat.
interface kernel_mac_conv_if #(
    parameter int PIX_W  = 4,
    parameter int COEF_W = 5,
    parameter int K      = 3,
    parameter int OUT_W  = 10
);
    logic                     start;
    logic [K*K*PIX_W-1:0]     pixels;
    logic [K*K*COEF_W-1:0]    coefs;
    logic                     busy;
    logic                     done;
    logic [OUT_W-1:0]         result;
    logic                     sat;

    modport master (
        output start, pixels, coefs,
        input  busy, done, result, sat
    );

    modport slave (
        input  start, pixels, coefs,
        output busy, done, result, sat
    );
endinterface

// File: rtl/kernel_mac_conv.sv
// Sequential KxK convolution engine: one shared multiplier, one tap per cycle.
// A window and a signed kernel are captured on an accepted start. Each MAC
// cycle registers one product while the accumulator adds the product from the
// previous cycle. The DRAIN cycle folds in the last product and saturates.
// Optional build macro CONV_ABS_EN: the result is |sum| clipped to max positive.
module kernel_mac_conv #(
    parameter int PIX_W  = 4,
    parameter int COEF_W = 5,
    parameter int K      = 3,
    parameter int OUT_W  = 10
) (
    input  logic              clk,
    input  logic              n_rst,
    kernel_mac_conv_if.slave  bus
);
    localparam int TAPS   = K * K;
    localparam int IDX_W  = $clog2(TAPS);
    localparam int ACC_W  = PIX_W + COEF_W + 1 + $clog2(TAPS);
    localparam int PROD_W = PIX_W + COEF_W + 1;

    // The saturation bounds are held one bit wider than the accumulator,
    // so that negating the most negative sum cannot wrap.
    localparam logic signed [ACC_W:0] MAX_POS = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] MIN_NEG = (ACC_W+1)'(-(2**(OUT_W-1)));

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN
    } state_t;

    state_t                    state;
    state_t                    state_next;

    logic [TAPS*PIX_W-1:0]     pix_q;
    logic [TAPS*COEF_W-1:0]    coef_q;
    logic [IDX_W-1:0]          idx;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [OUT_W-1:0]          result_q;
    logic                      sat_q;
    logic                      done_q;

    logic                      accept;
    logic [PIX_W-1:0]          pix_tap;
    logic [COEF_W-1:0]         coef_tap;
    logic signed [PROD_W-1:0]  pix_ext;
    logic signed [PROD_W-1:0]  coef_ext;
    logic signed [PROD_W-1:0]  prod_next;
    logic signed [ACC_W-1:0]   sum_final;
    logic signed [ACC_W:0]     sum_ext;
    logic signed [ACC_W:0]     clip_val;
    logic                      sat_next;

    assign accept     = (state == IDLE) && bus.start;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.sat    = sat_q;

    // State register; a reset drops any operation in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: the last tap issues from MAC, and one DRAIN cycle follows it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = MAC;
            MAC:     if (idx == IDX_W'(TAPS - 1)) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Tap selection and product. The pixel is zero-extended before the signed multiply.
    always_comb begin
        pix_tap   = pix_q[idx*PIX_W +: PIX_W];
        coef_tap  = coef_q[idx*COEF_W +: COEF_W];
        pix_ext   = PROD_W'(pix_tap);
        coef_ext  = PROD_W'($signed(coef_tap));
        prod_next = pix_ext * coef_ext;
    end

    // Final sum and clipping to OUT_W, optionally taking the magnitude first.
    always_comb begin
        sum_final = acc_q + ACC_W'(prod_q);
        sum_ext   = (ACC_W+1)'(sum_final);
`ifdef CONV_ABS_EN
        if (sum_ext < 0) sum_ext = -sum_ext;
`else
        sum_ext   = sum_ext;
`endif
        clip_val  = sum_ext;
        sat_next  = 1'b0;
        if (sum_ext > MAX_POS) begin
            clip_val = MAX_POS;
            sat_next = 1'b1;
        end else if (sum_ext < MIN_NEG) begin
            clip_val = MIN_NEG;
            sat_next = 1'b1;
        end
    end

    // Datapath: capture on accept, multiply-accumulate during MAC, publish on DRAIN.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pix_q    <= '0;
            coef_q   <= '0;
            idx      <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pix_q  <= bus.pixels;
                        coef_q <= bus.coefs;
                        idx    <= '0;
                        prod_q <= '0;
                        acc_q  <= '0;
                    end
                end
                MAC: begin
                    prod_q <= prod_next;
                    idx    <= idx + IDX_W'(1);
                    acc_q  <= acc_q + ACC_W'(prod_q);
                end
                DRAIN: begin
                    acc_q    <= sum_final;
                    result_q <= clip_val[OUT_W-1:0];
                    sat_q    <= sat_next;
                    done_q   <= 1'b1;
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
